// File: rtl/q_requant_drain_pkg.sv
// Shared constants and types for the Q-projection datapath: widths,
// the drain FSM state encoding and the accumulator/element typedefs.
package q_proj_pkg;

  localparam int N           = 4;
  localparam int ACC_WIDTH   = 32;
  localparam int DATA_WIDTH  = 8;
  localparam int MULT_WIDTH  = 16;
  localparam int SHIFT_WIDTH = 5;
  localparam int ROW_WIDTH   = 2;

  // Full signed product of accumulator and multiplier, plus one guard bit
  // so the rounding bias can never overflow.
  localparam int PROD_WIDTH  = ACC_WIDTH + MULT_WIDTH;
  localparam int RND_WIDTH   = PROD_WIDTH + 1;

  typedef logic signed [ACC_WIDTH-1:0]  acc_t;
  typedef logic signed [DATA_WIDTH-1:0] elem_t;
  typedef logic signed [MULT_WIDTH-1:0] mult_t;
  typedef logic [SHIFT_WIDTH-1:0]       shift_t;
  typedef logic signed [PROD_WIDTH-1:0] prod_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/q_requant_drain_if.sv
// Tile-in / row-out bundle between the systolic array stage, the requant
// drain and the activation writeback buffer.
interface q_requant_drain_if;
  import q_proj_pkg::*;

  logic                         in_valid;
  logic [N*N*ACC_WIDTH-1:0]     matrix_c;
  mult_t                        mult;
  shift_t                       shift;
  elem_t                        zero_point;
  logic                         in_ready;

  logic                         out_valid;
  logic                         out_ready;
  logic [N*DATA_WIDTH-1:0]      out_row;
  logic [ROW_WIDTH-1:0]         out_row_idx;
  logic                         out_last;
  logic [N-1:0]                 out_sat;
  logic                         drop_err;

  // Producer/consumer side: supplies tiles and accepts rows.
  modport master (
    output in_valid, matrix_c, mult, shift, zero_point, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, out_last, out_sat, drop_err
  );

  // Drain side: consumes tiles and presents rows.
  modport slave (
    input  in_valid, matrix_c, mult, shift, zero_point, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, out_last, out_sat, drop_err
  );

endinterface

// File: rtl/q_requant_drain_lane.sv
// One output lane of the requantizer: round-half-up arithmetic right shift
// of the registered product, add the zero-point, clamp to the int8 range.
module requant_lane
  import q_proj_pkg::*;
(
  input  prod_t  prod,
  input  shift_t shift,
  input  elem_t  zero_point,
  output elem_t  q,
  output logic   sat
);

  localparam int V_WIDTH = RND_WIDTH + 1;
  localparam logic signed [V_WIDTH-1:0] Q_MAX = V_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [V_WIDTH-1:0] Q_MIN = V_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

  logic signed [RND_WIDTH-1:0] prod_ext;
  logic signed [RND_WIDTH-1:0] bias;
  logic signed [RND_WIDTH-1:0] biased;
  logic signed [RND_WIDTH-1:0] rounded;
  logic signed [V_WIDTH-1:0]   v;

  // Rounding shift, zero-point offset and saturation; a zero shift passes the product through untouched.
  always_comb begin
    prod_ext = RND_WIDTH'(prod);
    bias     = '0;
    biased   = prod_ext;
    rounded  = prod_ext;
    if (shift != '0) begin
      bias    = RND_WIDTH'(1) << (shift - shift_t'(1));
      biased  = prod_ext + bias;
      rounded = biased >>> shift;
    end
    v   = V_WIDTH'(rounded) + V_WIDTH'(zero_point);
    q   = v[DATA_WIDTH-1:0];
    sat = 1'b0;
    if (v > Q_MAX) begin
      q   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat = 1'b1;
    end else if (v < Q_MIN) begin
      q   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/q_requant_drain.sv
// Requantize drain: captures a 4x4 int32 accumulator tile, multiplies one
// row per MUL cycle, then presents the int8 row on a valid/ready stream.
// Tiles that arrive while a drain is in progress are dropped and flagged.
module q_requant_drain
  import q_proj_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  q_requant_drain_if.slave   bus
);

  state_t               state;
  state_t               state_next;

  acc_t                 acc_q [N*N];
  mult_t                mult_q;
  shift_t               shift_q;
  elem_t                zp_q;
  prod_t                prod_q [N];
  logic [ROW_WIDTH-1:0] row_q;
  logic                 drop_q;

  elem_t                lane_q [N];
  logic [N-1:0]         lane_sat;
  logic [N*DATA_WIDTH-1:0] out_row_w;

  logic                 capture;
  logic                 handshake;
  logic                 last_row;

  assign capture   = (state == IDLE) && bus.in_valid;
  assign handshake = (state == EMIT) && bus.out_ready;
  assign last_row  = (row_q == ROW_WIDTH'(N - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: one MUL cycle per row, EMIT waits for the consumer.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_next = MUL;
      MUL:     state_next = EMIT;
      EMIT:    if (bus.out_ready) state_next = last_row ? IDLE : MUL;
      default: state_next = IDLE;
    endcase
  end

  // Tile capture; the accumulators need no reset since nothing reads them before a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N*N; i++) begin
        acc_q[i] <= bus.matrix_c[i*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  // Per-tile requant parameters, cleared on reset so the idle output row reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mult_q  <= '0;
      shift_q <= '0;
      zp_q    <= '0;
    end else if (capture) begin
      mult_q  <= bus.mult;
      shift_q <= bus.shift;
      zp_q    <= bus.zero_point;
    end
  end

  // Row counter: restarts on capture, advances on every non-final row handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
    end else if (capture) begin
      row_q <= '0;
    end else if (handshake && !last_row) begin
      row_q <= row_q + ROW_WIDTH'(1);
    end
  end

  // Product register for the current row, loaded during MUL and held through EMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N; c++) prod_q[c] <= '0;
    end else if (state == MUL) begin
      for (int c = 0; c < N; c++) begin
        prod_q[c] <= prod_t'(acc_q[int'(row_q)*N + c]) * prod_t'(mult_q);
      end
    end
  end

  // Sticky drop flag for tiles offered while not idle.
  always_ff @(posedge clk) begin
    if (rst)                                drop_q <= 1'b0;
    else if (bus.in_valid && state != IDLE) drop_q <= 1'b1;
  end

  for (genvar c = 0; c < N; c++) begin : g_lane
    requant_lane u_lane (
      .prod       (prod_q[c]),
      .shift      (shift_q),
      .zero_point (zp_q),
      .q          (lane_q[c]),
      .sat        (lane_sat[c])
    );
    assign out_row_w[c*DATA_WIDTH +: DATA_WIDTH] = lane_q[c];
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == EMIT);
  assign bus.out_row     = out_row_w;
  assign bus.out_row_idx = row_q;
  assign bus.out_last    = (state == EMIT) && last_row;
  assign bus.out_sat     = lane_sat;
  assign bus.drop_err    = drop_q;

endmodule

// File: tb/tb_q_requant_drain.sv
// Randomized scoreboard bench for q_requant_drain: accepted tiles push their
// expected rows, a negedge monitor pops and compares on every handshake and
// checks that stalled rows stay put.
module tb_q_requant_drain;
  import q_proj_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  q_requant_drain_if bus ();

  q_requant_drain dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N*DATA_WIDTH-1:0] row;
    logic [1:0]              idx;
    logic                    last;
    logic [N-1:0]            sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tile [N*N];
  bit   rand_ready   = 1'b0;
  bit   forced_ready = 1'b1;

  // Generic comparison used by the directed checks and the monitor.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: floor-division rounding, offset, clamp, one entry per row.
  function automatic void pushExpected(input int m, input int sh, input int zp);
    for (int r = 0; r < N; r++) begin
      exp_t e;
      e.row  = '0;
      e.sat  = '0;
      e.idx  = 2'(r);
      e.last = (r == N - 1);
      for (int c = 0; c < N; c++) begin
        longint p, num, d, rr, v;
        p = longint'(tile[r*N + c]) * longint'(m);
        if (sh == 0) begin
          rr = p;
        end else begin
          d   = longint'(1) << sh;
          num = p + d / 2;
          rr  = num / d;
          if ((num % d) != 0 && num < 0) rr = rr - 1;
        end
        v = rr + zp;
        if (v > 127) begin
          v = 127;
          e.sat[c] = 1'b1;
        end else if (v < -128) begin
          v = -128;
          e.sat[c] = 1'b1;
        end
        e.row[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(v);
      end
      sb.push_back(e);
    end
  endfunction

  task automatic randomTile();
    for (int i = 0; i < N*N; i++) begin
      if ($urandom_range(0, 1) == 0) tile[i] = int'($urandom_range(0, 2000)) - 1000;
      else                           tile[i] = int'($urandom);
    end
  endtask

  // Offer the current tile for one cycle; afterwards scramble the inputs to show they are not re-read.
  task automatic applyStimulus(input int m, input int sh, input int zp, input bit accept);
    int n = 0;
    if (accept) begin
      while (!bus.in_ready && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (!bus.in_ready) begin
        checks++;
        errors++;
        $display("[TB] FAIL in_ready_wait: in_ready=0 after %0d cycles, required 1", n);
      end
    end
    for (int i = 0; i < N*N; i++) bus.matrix_c[i*ACC_WIDTH +: ACC_WIDTH] = tile[i];
    bus.mult       = mult_t'(m);
    bus.shift      = shift_t'(sh);
    bus.zero_point = elem_t'(zp);
    bus.in_valid   = 1'b1;
    if (accept) pushExpected(m, sh, zp);
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    bus.mult       = mult_t'($urandom);
    bus.shift      = shift_t'($urandom);
    bus.zero_point = elem_t'($urandom);
    for (int i = 0; i < N*N; i++) bus.matrix_c[i*ACC_WIDTH +: ACC_WIDTH] = $urandom;
  endtask

  task automatic waitRow(input int idx);
    int n = 0;
    while (!(bus.out_valid && bus.out_row_idx == 2'(idx)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("wait_row_valid", {63'd0, bus.out_valid && bus.out_row_idx == 2'(idx)}, 64'd1);
  endtask

  // Consumer ready: random or forced, updated just after each rising edge.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
    end
  end

  // Monitor: pop and compare on each handshake, verify held data during stalls.
  logic                    stalled = 1'b0;
  logic [N*DATA_WIDTH-1:0] held_row;
  logic [1:0]              held_idx;
  logic [N-1:0]            held_sat;
  logic                    held_last;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("hold_stable",
                    {24'd0, bus.out_valid, bus.out_row, bus.out_row_idx, bus.out_sat, bus.out_last},
                    {24'd0, 1'b1, held_row, held_idx, held_sat, held_last});
      end
      stalled = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_row: row 0x%0h idx %0d with empty scoreboard", bus.out_row, bus.out_row_idx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("row_data",
                      {25'd0, bus.out_row, bus.out_row_idx, bus.out_last, bus.out_sat},
                      {25'd0, e.row, e.idx, e.last, e.sat});
        end
      end else if (bus.out_valid) begin
        stalled   = 1'b1;
        held_row  = bus.out_row;
        held_idx  = bus.out_row_idx;
        held_sat  = bus.out_sat;
        held_last = bus.out_last;
      end
    end
  end

  initial begin
    int n;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.matrix_c   = '0;
    bus.mult       = '0;
    bus.shift      = '0;
    bus.zero_point = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready",  {63'd0, bus.in_ready},    64'd1);
    checkOutput("reset_out_valid", {63'd0, bus.out_valid},   64'd0);
    checkOutput("reset_out_row",   {32'd0, bus.out_row},     64'd0);
    checkOutput("reset_row_idx",   {62'd0, bus.out_row_idx}, 64'd0);
    checkOutput("reset_out_last",  {63'd0, bus.out_last},    64'd0);
    checkOutput("reset_out_sat",   {60'd0, bus.out_sat},     64'd0);
    checkOutput("reset_drop_err",  {63'd0, bus.drop_err},    64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity with ready held high: latency and full-tile throughput.
    rand_ready = 1'b0;
    forced_ready = 1'b1;
    randomTile();
    tile[0] = 5; tile[1] = -3; tile[2] = 127; tile[3] = -128;
    applyStimulus(1, 0, 0, 1'b1);
    checkOutput("lat_in_ready_low",  {63'd0, bus.in_ready},  64'd0);
    checkOutput("lat_valid_not_yet", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk); #1;
    checkOutput("lat_row0_valid", {63'd0, bus.out_valid}, 64'd1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("tput_busy_before_last", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk); #1;
    checkOutput("tput_ready_after_last", {63'd0, bus.in_ready}, 64'd1);

    // Rounding and saturation/zero-point vectors under random backpressure.
    rand_ready = 1'b1;
    randomTile();
    tile[0] = 10; tile[1] = -10; tile[2] = 1; tile[3] = -2;
    applyStimulus(3, 2, 0, 1'b1);
    randomTile();
    tile[0] = 1000; tile[1] = -1000; tile[2] = 117; tile[3] = 118;
    applyStimulus(1, 0, 10, 1'b1);

    // Backpressure: five stalled cycles on row 1.
    n = 0;
    while (sb.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
    rand_ready = 1'b0;
    forced_ready = 1'b1;
    randomTile();
    applyStimulus(int'($urandom_range(0, 65535)) - 32768, 12, 3, 1'b1);
    waitRow(1);
    forced_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bp_row1_held", {61'd0, bus.out_valid, bus.out_row_idx}, {61'd0, 1'b1, 2'd1});
    forced_ready = 1'b1;

    // Drop: a second tile three cycles into a drain.
    rand_ready = 1'b1;
    randomTile();
    applyStimulus(int'($urandom_range(0, 65535)) - 32768, 16, -5, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    randomTile();
    applyStimulus(7, 1, 1, 1'b0);
    checkOutput("drop_err_set", {63'd0, bus.drop_err}, 64'd1);
    randomTile();
    applyStimulus(2, 1, -1, 1'b1);

    // Reset during row 2.
    rand_ready = 1'b0;
    forced_ready = 1'b1;
    randomTile();
    applyStimulus(int'($urandom_range(0, 65535)) - 32768, 20, 0, 1'b1);
    waitRow(2);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    checkOutput("rst_mid_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("rst_mid_in_ready",  {63'd0, bus.in_ready},  64'd1);
    checkOutput("rst_mid_drop_err",  {63'd0, bus.drop_err},  64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    randomTile();
    applyStimulus(1, 0, 0, 1'b1);

    // Random tiles with random parameters and random ready.
    rand_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      randomTile();
      applyStimulus(int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 255)) - 128, 1'b1);
    end

    n = 0;
    while (sb.size() != 0 && n < 3000) begin @(posedge clk); #1; n++; end
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
